// File: rtl/imem_bootloader.sv
// imem_bootloader
//   Loads a program image into instruction memory from a length-prefixed,
//   little-endian byte stream (valid/ready) while holding the core in reset.
//   Words are written to byte addresses 0, 4, 8, ... and the core is released
//   once the whole image has landed.
//   Optional feature macro: BOOT_CHECKSUM_EN -- when defined, one trailing byte
//   must equal the XOR of all data bytes before the core is released.
module imem_bootloader #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_w_enb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_w_data,
  output logic        core_rst,
  output logic        done,
  output logic        error
);

  // Largest image that fits the instruction memory, in 32-bit words.
  localparam logic [31:0] MAX_WORDS = 32'd1 << (ADDR_BITS - 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHK   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  logic [1:0]  byte_cnt_r;
  logic [23:0] shift_r;     // the three most recent bytes of the word being assembled
  logic [31:0] remain_r;    // words still to be written
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        in_ready_r;
  logic        w_enb_r;
  logic        core_rst_r;
  logic        done_r;
  logic        error_r;

  logic        accept_s;
  logic        last_byte_s;
  logic        restart_s;
  logic [31:0] word_s;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  csum_r;

  // Running XOR checksum over the data bytes.
  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  // Byte transfer qualification and the word formed by the current byte plus history.
  always_comb begin
    accept_s    = in_valid & in_ready_r;
    last_byte_s = accept_s & (byte_cnt_r == 2'd3);
    word_s      = {in_data, shift_r};
    restart_s   = start & ((state_r == ST_IDLE) | (state_r == ST_DONE) | (state_r == ST_ERR));
  end

  // Next-state logic for the load sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (restart_s) begin
          state_nxt_s = ST_LEN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_LEN: begin
        if (last_byte_s) begin
          if (word_s > MAX_WORDS) begin
            state_nxt_s = ST_ERR;
          end else if (word_s == 32'd0) begin
`ifdef BOOT_CHECKSUM_EN
            state_nxt_s = ST_CHK;
`else
            state_nxt_s = ST_DONE;
`endif
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_LEN;
        end
      end
      ST_DATA: begin
        if (last_byte_s) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_WRITE: begin
        if (remain_r == 32'd1) begin
`ifdef BOOT_CHECKSUM_EN
          state_nxt_s = ST_CHK;
`else
          state_nxt_s = ST_DONE;
`endif
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CHK: begin
        if (accept_s) begin
          if (in_data == csum_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ERR;
          end
        end else begin
          state_nxt_s = ST_CHK;
        end
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Byte assembly, word counting and write address/data tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_r <= 2'd0;
      shift_r    <= 24'd0;
      remain_r   <= 32'd0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
      csum_r     <= 8'd0;
`endif
    end else begin
      if (restart_s) begin
        byte_cnt_r <= 2'd0;
        addr_r     <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
        csum_r     <= 8'd0;
`endif
      end else if (accept_s) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        shift_r    <= word_s[31:8];
        if ((state_r == ST_LEN) && last_byte_s) begin
          remain_r <= word_s;
        end
        if (state_r == ST_DATA) begin
`ifdef BOOT_CHECKSUM_EN
          csum_r <= csum_update(csum_r, in_data);
`endif
          if (last_byte_s) begin
            wdata_r <= word_s;
          end
        end
      end else if (state_r == ST_WRITE) begin
        addr_r   <= addr_r + 32'd4;
        remain_r <= remain_r - 32'd1;
      end
    end
  end

  // Registered status/handshake outputs, aligned with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_r <= 1'b0;
      w_enb_r    <= 1'b0;
      core_rst_r <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      in_ready_r <= (state_nxt_s == ST_LEN) | (state_nxt_s == ST_DATA) | (state_nxt_s == ST_CHK);
      w_enb_r    <= (state_nxt_s == ST_WRITE);
      core_rst_r <= (state_nxt_s != ST_DONE);
      done_r     <= (state_nxt_s == ST_DONE);
      error_r    <= (state_nxt_s == ST_ERR);
    end
  end

  assign in_ready   = in_ready_r;
  assign mem_w_enb  = w_enb_r;
  assign mem_addr   = addr_r;
  assign mem_w_data = wdata_r;
  assign core_rst   = core_rst_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule

// File: tb/tb_imem_bootloader.sv
// tb_imem_bootloader
//   Directed bench for imem_bootloader. A queue-based model lists the writes a
//   load must produce (word i at byte address 4*i) and the final status; a
//   monitor compares every memory write against it. Hand-computed literals
//   pin the byte order and checksum. Honours BOOT_CHECKSUM_EN.
module tb_imem_bootloader;
  localparam int          ADDR_BITS = 10;
  localparam logic [31:0] MAX_WORDS = 32'd256;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_w_enb;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic        core_rst;
  logic        done;
  logic        error;

  imem_bootloader #(.ADDR_BITS(ADDR_BITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_w_enb  (mem_w_enb),
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] job_words[$];
  logic [31:0] last_wr_addr = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Every write the DUT performs must be the next one the model expects.
  always @(negedge clk) begin
    logic [31:0] ea;
    logic [31:0] ed;
    if (rst === 1'b1 && mem_w_enb === 1'b1) begin
      last_wr_addr = mem_addr;
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h expected=none", mem_addr, mem_w_data);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        check("write_addr", mem_addr, ea);
        check("write_data", mem_w_data, ed);
      end
    end
  end

  task automatic check_reset_state(input string name);
    check({name, "_in_ready"},   {31'd0, in_ready},  32'd0);
    check({name, "_mem_w_enb"},  {31'd0, mem_w_enb}, 32'd0);
    check({name, "_mem_addr"},   mem_addr,           32'd0);
    check({name, "_mem_w_data"}, mem_w_data,         32'd0);
    check({name, "_core_rst"},   {31'd0, core_rst},  32'd1);
    check({name, "_done"},       {31'd0, done},      32'd0);
    check({name, "_error"},      {31'd0, error},     32'd0);
  endtask

  // Pulse start for one cycle, then confirm the load has begun cleanly.
  task automatic begin_load(input string name);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({name, "_start_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({name, "_start_core_rst"}, {31'd0, core_rst}, 32'd1);
    check({name, "_start_done"},     {31'd0, done},     32'd0);
    check({name, "_start_error"},    {31'd0, error},    32'd0);
    check({name, "_start_addr"},     mem_addr,          32'd0);
    @(posedge clk); #1;
  endtask

  // Offer one byte until it is taken; optionally idle one cycle first.
  task automatic send_byte(input logic [7:0] b, input bit toggle);
    int guard;
    if (toggle) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      guard++;
      if (guard > 40) begin
        checks++;
        errors++;
        $display("FAIL byte_timeout in_ready=%b expected=1", in_ready);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit toggle);
    send_byte(w[7:0], toggle);
    send_byte(w[15:8], toggle);
    send_byte(w[23:16], toggle);
    send_byte(w[31:24], toggle);
  endtask

  // Wait (bounded) for the load to finish and check the final status.
  task automatic wait_end(input bit exp_err, input string name);
    int guard;
    guard = 0;
    @(negedge clk);
    while (done !== 1'b1 && error !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_done"},     {31'd0, done},     {31'd0, ~exp_err});
    check({name, "_error"},    {31'd0, error},    {31'd0, exp_err});
    check({name, "_core_rst"}, {31'd0, core_rst}, {31'd0, exp_err});
    check({name, "_pending_writes"}, exp_addr_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // Full load of job_words[0..n-1]; the model derives writes and outcome.
  task automatic run_job(input logic [31:0] n, input bit toggle, input bit poke_start,
                         input string name);
    bit exp_err;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0] cs;
    cs = 8'h00;
`endif
    exp_err = (n > MAX_WORDS);
    begin_load(name);
    if (!exp_err) begin
      for (int i = 0; i < int'(n); i++) begin
        exp_addr_q.push_back(32'(i) * 32'd4);
        exp_data_q.push_back(job_words[i]);
`ifdef BOOT_CHECKSUM_EN
        cs = cs ^ job_words[i][7:0] ^ job_words[i][15:8] ^ job_words[i][23:16] ^ job_words[i][31:24];
`endif
      end
    end
    send_word(n, toggle);
    if (!exp_err) begin
      if (poke_start && n != 32'd0) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      for (int i = 0; i < int'(n); i++) begin
        send_word(job_words[i], toggle);
      end
`ifdef BOOT_CHECKSUM_EN
      send_byte(cs, toggle);
`endif
    end
    wait_end(exp_err, name);
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: single word, stream bytes written out by hand.
    begin_load("t1");
    exp_addr_q.push_back(32'h0000_0000);
    exp_data_q.push_back(32'hDEAD_BEEF);
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'hEF, 1'b0); send_byte(8'hBE, 1'b0);
    send_byte(8'hAD, 1'b0); send_byte(8'hDE, 1'b0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h22, 1'b0);
`endif
    wait_end(1'b0, "t1");

    // 2: three words with gapped valid; a stray start mid-load is ignored.
    job_words = {32'd1, 32'd2, 32'd3};
    run_job(32'd3, 1'b1, 1'b1, "t2");

    // 3: one word too many is rejected, then the maximum image loads.
    job_words.delete();
    run_job(32'd257, 1'b0, 1'b0, "t3_over");
    for (int i = 0; i < 256; i++) job_words.push_back(32'hA500_0000 ^ (32'(i) * 32'h0001_0203));
    run_job(32'd256, 1'b0, 1'b0, "t3_max");
    check("t3_last_addr", last_wr_addr, 32'h0000_03FC);

    // 4: reset mid-word discards the partial load.
    begin_load("t4a");
    send_word(32'd1, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    @(negedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("t4_rst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    job_words = {32'h1234_5678};
    run_job(32'd1, 1'b0, 1'b0, "t4b");

    // 5: empty image.
    begin_load("t5");
    send_word(32'd0, 1'b0);
    @(negedge clk);
`ifdef BOOT_CHECKSUM_EN
    check("t5_wait_csum_done", {31'd0, done},     32'd0);
    check("t5_wait_csum_rdy",  {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    send_byte(8'h00, 1'b0);
    wait_end(1'b0, "t5_csum");
`else
    check("t5_done_next", {31'd0, done},     32'd1);
    check("t5_core_rst",  {31'd0, core_rst}, 32'd0);
    @(posedge clk); #1;
`endif

`ifdef BOOT_CHECKSUM_EN
    // 6: checksum of 01 02 03 04 is 04; 05 must be rejected.
    begin_load("t6a");
    exp_addr_q.push_back(32'h0000_0000);
    exp_data_q.push_back(32'h0403_0201);
    send_word(32'd1, 1'b0);
    send_word(32'h0403_0201, 1'b0);
    send_byte(8'h04, 1'b0);
    wait_end(1'b0, "t6_good");
    begin_load("t6b");
    exp_addr_q.push_back(32'h0000_0000);
    exp_data_q.push_back(32'h0403_0201);
    send_word(32'd1, 1'b0);
    send_word(32'h0403_0201, 1'b0);
    send_byte(8'h05, 1'b0);
    wait_end(1'b1, "t6_bad");
`endif

    // Quiet tail: no further writes may appear.
    repeat (5) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
